// File: rtl/m_dram_responder.sv
// m_dram_responder: memory-side responder for the MMU DRAM port.
//
// This is a single-port, word-organised RAM that serves page-walk reads, PTE A/D updates,
// instruction fetches, and data loads and stores. Every request gets a registered busy
// handshake with fixed latency. Loads can be byte, half or word, with sign or zero extension.
// SB and SH stores are done as a read-modify-write of the target word.
//
// Optional feature macro: MEMRSP_BOUNDS_EN
//   Defined:   a word offset addr[27:2] >= MEM_WORDS is treated as out of range. Loads return 0,
//              stores are dropped, and w_dram_err pulses for one cycle after completion. Timing
//              is the same as for an in-range access.
//   Undefined: w_dram_err is tied to 0 and the word index wraps modulo MEM_WORDS.
//
// Ports:
//   CLK           in   clock
//   RST_X         in   asynchronous active-low reset (RAM contents are kept)
//   w_dram_addr   in   byte address: [31:28] region, [AW+1:2] word index, [1:0] byte lane
//   w_dram_wdata  in   store data, right-aligned
//   w_dram_we_t   in   write request (wins over w_dram_le)
//   w_dram_le     in   load request
//   w_dram_ctrl   in   funct3 access size / signedness
//   w_dram_odata  out  last load result, held until the next load completes
//   w_dram_busy   out  request in progress
//   w_dram_err    out  one-cycle out-of-range pulse (only with MEMRSP_BOUNDS_EN)
module m_dram_responder #(
  parameter int unsigned MEM_WORDS = 16384,
  parameter int unsigned LATENCY   = 4
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic [31:0] w_dram_addr,
  input  logic [31:0] w_dram_wdata,
  input  logic        w_dram_we_t,
  input  logic        w_dram_le,
  input  logic [2:0]  w_dram_ctrl,
  output logic [31:0] w_dram_odata,
  output logic        w_dram_busy,
  output logic        w_dram_err
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_READ     = 2'd1;
  localparam logic [1:0] S_WRITE_RD = 2'd2;
  localparam logic [1:0] S_WRITE_WR = 2'd3;

  localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

  logic [1:0]  r_state, w_state_d;
  logic [3:0]  r_cnt, w_cnt_d;
  logic [27:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_ctrl;
  logic [31:0] r_rdword;
  logic [31:0] r_odata;

  logic [31:0] r_mem [MEM_WORDS];

  logic        w_region_ok;
  logic        w_accept;
  logic        w_rd_done;
  logic        w_wr_done;
  logic        w_oob;
  logic        w_mem_we;
  logic [AW-1:0] w_idx;
  logic [31:0] w_mem_rdata;
  logic [31:0] w_load_val;
  logic [31:0] w_merged;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_region_ok = (w_dram_addr[31:28] == 4'h0) || (w_dram_addr[31:28] == 4'h8) ||
                       (w_dram_addr[31:28] == 4'h9);
  assign w_accept    = (r_state == S_IDLE) && w_region_ok && (w_dram_we_t || w_dram_le);

  assign w_idx       = r_addr[AW+1:2];
  assign w_mem_rdata = r_mem[w_idx];

  assign w_rd_done   = (r_state == S_READ) && (r_cnt == LAT_LAST);
  // WRITE_WR is entered with one cycle already spent in WRITE_RD, so writes take at least 2.
  assign w_wr_done   = (r_state == S_WRITE_WR) && (r_cnt >= LAT_LAST);

`ifdef MEMRSP_BOUNDS_EN
  assign w_oob = (32'(r_addr[27:2]) >= MEM_WORDS);
`else
  assign w_oob = 1'b0;
  // Offset bits above the word index are dropped, so the index wraps.
  logic w_unused_addr;
  assign w_unused_addr = ^r_addr[27:AW+2];
`endif

  // The write happens only on the completion edge, so a reset mid-op leaves the RAM untouched.
  assign w_mem_we = w_wr_done && !w_oob;

  // Next-state and counter logic.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_d = 4'd0;
        if (w_accept) begin
          w_state_d = w_dram_we_t ? S_WRITE_RD : S_READ;
        end
      end
      S_READ: begin
        if (w_rd_done) begin
          w_state_d = S_IDLE;
          w_cnt_d   = 4'd0;
        end else begin
          w_cnt_d = r_cnt + 4'd1;
        end
      end
      S_WRITE_RD: begin
        w_state_d = S_WRITE_WR;
        w_cnt_d   = 4'd1;
      end
      S_WRITE_WR: begin
        if (w_wr_done) begin
          w_state_d = S_IDLE;
          w_cnt_d   = 4'd0;
        end else begin
          w_cnt_d = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_d = S_IDLE;
        w_cnt_d   = 4'd0;
      end
    endcase
  end

  // Pick the byte and half-word lanes of the word being read.
  always_comb begin
    w_byte = w_mem_rdata[7:0];
    unique case (r_addr[1:0])
      2'd0: w_byte = w_mem_rdata[7:0];
      2'd1: w_byte = w_mem_rdata[15:8];
      2'd2: w_byte = w_mem_rdata[23:16];
      2'd3: w_byte = w_mem_rdata[31:24];
      default: w_byte = w_mem_rdata[7:0];
    endcase
    w_half = r_addr[1] ? w_mem_rdata[31:16] : w_mem_rdata[15:0];
  end

  // Extend the selected lane. Undefined funct3 codes load a full word.
  always_comb begin
    w_load_val = w_mem_rdata;
    case (r_ctrl)
      3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_val = {24'h0, w_byte};
      3'b101:  w_load_val = {16'h0, w_half};
      default: w_load_val = w_mem_rdata;
    endcase
    if (w_oob) begin
      w_load_val = 32'h0;
    end
  end

  // Merge the store data into the word captured in WRITE_RD. Any other code stores a full word.
  always_comb begin
    w_merged = r_wdata;
    case (r_ctrl)
      3'b000: begin
        w_merged = r_rdword;
        for (int i = 0; i < 4; i++) begin
          if (r_addr[1:0] == 2'(i)) begin
            w_merged[8*i +: 8] = r_wdata[7:0];
          end
        end
      end
      3'b001: begin
        w_merged = r_addr[1] ? {r_wdata[15:0], r_rdword[15:0]}
                             : {r_rdword[31:16], r_wdata[15:0]};
      end
      default: w_merged = r_wdata;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_addr   <= 28'h0;
      r_wdata  <= 32'h0;
      r_ctrl   <= 3'b000;
      r_rdword <= 32'h0;
      r_odata  <= 32'h0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_accept) begin
        r_addr  <= w_dram_addr[27:0];
        r_wdata <= w_dram_wdata;
        r_ctrl  <= w_dram_ctrl;
      end
      if (r_state == S_WRITE_RD) begin
        r_rdword <= w_mem_rdata;
      end
      if (w_rd_done) begin
        r_odata <= w_load_val;
      end
    end
  end

  // RAM array: no reset, so its contents survive RST_X.
  always_ff @(posedge CLK) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= w_merged;
    end
  end

`ifdef MEMRSP_BOUNDS_EN
  logic r_err;
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (w_rd_done || w_wr_done) && w_oob;
    end
  end
  assign w_dram_err = r_err;
`else
  assign w_dram_err = 1'b0;
`endif

  assign w_dram_odata = r_odata;
  assign w_dram_busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_m_dram_responder.sv
// Testbench for m_dram_responder. It mixes directed scenarios with randomized loads and stores,
// and checks them against a word-level memory model held in an associative array.
module tb_m_dram_responder;

  localparam int unsigned MEM_WORDS = 16384;
  localparam int unsigned LATENCY   = 4;
`ifdef MEMRSP_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif
  localparam int unsigned WR_CYCLES = (LATENCY > 2) ? LATENCY : 2;

  logic        CLK = 1'b0;
  logic        RST_X;
  logic [31:0] addr, wdata;
  logic        we_t, le;
  logic [2:0]  ctrl;
  logic [31:0] odata;
  logic        busy, err;

  m_dram_responder #(.MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY)) dut (
    .CLK          (CLK),
    .RST_X        (RST_X),
    .w_dram_addr  (addr),
    .w_dram_wdata (wdata),
    .w_dram_we_t  (we_t),
    .w_dram_le    (le),
    .w_dram_ctrl  (ctrl),
    .w_dram_odata (odata),
    .w_dram_busy  (busy),
    .w_dram_err   (err)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // Reference model.
  logic [31:0] mdl_mem [int];
  logic [31:0] exp_odata;

  function automatic bit region_ok(input logic [31:0] a);
    return (a[31:28] == 4'h0) || (a[31:28] == 4'h8) || (a[31:28] == 4'h9);
  endfunction

  function automatic bit is_oob(input logic [31:0] a);
    longint unsigned off;
    off = longint'(a[27:2]);
    return BOUNDS && (off >= MEM_WORDS);
  endfunction

  function automatic int word_idx(input logic [31:0] a);
    longint unsigned off;
    off = longint'(a[27:2]);
    return int'(off % MEM_WORDS);
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [2:0] f);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    if (is_oob(a)) return 32'h0;
    w = mdl_mem.exists(word_idx(a)) ? mdl_mem[word_idx(a)] : 32'h0;
    b = w[8*a[1:0] +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic void mdl_store(input logic [31:0] a, input logic [2:0] f,
                                    input logic [31:0] d);
    logic [31:0] w;
    if (is_oob(a)) return;
    w = mdl_mem.exists(word_idx(a)) ? mdl_mem[word_idx(a)] : 32'h0;
    case (f)
      3'b000:  w[8*a[1:0] +: 8] = d[7:0];
      3'b001:  if (a[1]) w[31:16] = d[15:0]; else w[15:0] = d[15:0];
      default: w = d;
    endcase
    mdl_mem[word_idx(a)] = w;
  endfunction

  // Runs one request. It starts and ends at a negedge, holds the request while busy is high,
  // and checks latency, odata and err.
  task automatic do_op(input string tag, input logic w, input logic l, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] f);
    int n;
    int exp_n;
    bit act;
    bit oob;
    act   = region_ok(a) && (w || l);
    oob   = act && is_oob(a);
    exp_n = !act ? 0 : (w ? int'(WR_CYCLES) : int'(LATENCY));
    if (act && w) mdl_store(a, f, d);
    else if (act && l) exp_odata = mdl_load(a, f);
    addr = a; wdata = d; ctrl = f; we_t = w; le = l;
    n = 0;
    @(negedge CLK);
    while (busy && n < 40) begin
      n++;
      @(negedge CLK);
    end
    we_t = 1'b0; le = 1'b0;
    check({tag, "_cycles"}, 32'(n), 32'(exp_n));
    check({tag, "_odata"}, odata, exp_odata);
    check({tag, "_err"}, 32'(err), 32'(oob));
    @(negedge CLK);
    check({tag, "_err_clr"}, 32'(err), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] a;
    logic [3:0]  reg_sel [4];
    logic [2:0]  st_f [6];
    reg_sel = '{4'h0, 4'h8, 4'h9, 4'h4};
    st_f    = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    exp_odata = 32'h0;
    RST_X = 1'b0; addr = 32'h0; wdata = 32'h0; we_t = 1'b0; le = 1'b0; ctrl = 3'b0;
    #2;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_odata", odata, 32'h0);
    check("rst_err", 32'(err), 32'h0);
    repeat (2) @(negedge CLK);
    RST_X = 1'b1;
    @(negedge CLK);

    // Zero the words the bench uses, so the model and the RAM agree.
    for (int i = 0; i < 16; i++) begin
      do_op("init", 1'b1, 1'b0, 32'h8000_0000 + 32'(4 * i), 32'h0, 3'b010);
    end

    do_op("sw_beef", 1'b1, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 3'b010);
    do_op("lw_beef", 1'b0, 1'b1, 32'h8000_0010, 32'h0, 3'b010);
    check("lw_beef_const", odata, 32'hDEAD_BEEF);

    do_op("sw_base", 1'b1, 1'b0, 32'h8000_0010, 32'h1122_3344, 3'b010);
    do_op("sb_a5", 1'b1, 1'b0, 32'h8000_0011, 32'h0000_00A5, 3'b000);
    do_op("lw_mrg", 1'b0, 1'b1, 32'h8000_0010, 32'h0, 3'b010);
    check("lw_mrg_const", odata, 32'h1122_A544);
    do_op("lb", 1'b0, 1'b1, 32'h8000_0011, 32'h0, 3'b000);
    check("lb_const", odata, 32'hFFFF_FFA5);
    do_op("lbu", 1'b0, 1'b1, 32'h8000_0011, 32'h0, 3'b100);
    check("lbu_const", odata, 32'h0000_00A5);
    do_op("lh", 1'b0, 1'b1, 32'h8000_0012, 32'h0, 3'b001);
    check("lh_const", odata, 32'h0000_1122);

    // When we_t and le are both high, the write wins and odata keeps its value.
    do_op("both", 1'b1, 1'b1, 32'h8000_0020, 32'h0000_0055, 3'b010);
    check("both_odata_const", odata, 32'h0000_1122);
    do_op("both_rd", 1'b0, 1'b1, 32'h8000_0020, 32'h0, 3'b010);
    check("both_rd_const", odata, 32'h0000_0055);

    // Reset arrives during WRITE_WR: the store is abandoned.
    addr = 32'h8000_0030; wdata = 32'h1; ctrl = 3'b010; we_t = 1'b1;
    repeat (3) @(negedge CLK);
    #2 RST_X = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_odata", odata, 32'h0);
    check("midrst_err", 32'(err), 32'h0);
    exp_odata = 32'h0;
    we_t = 1'b0;
    @(negedge CLK);
    RST_X = 1'b1;
    @(negedge CLK);
    do_op("midrst_lw", 1'b0, 1'b1, 32'h8000_0030, 32'h0, 3'b010);

    // Out-of-range word offset: either wraps to word 0 or, with bounds checking, errors.
    do_op("w0", 1'b1, 1'b0, 32'h8000_0000, 32'hCAFE_F00D, 3'b010);
    do_op("oob_lw", 1'b0, 1'b1, 32'h8000_0000 + 32'(4 * MEM_WORDS), 32'h0, 3'b010);
    check("oob_lw_const", odata, BOUNDS ? 32'h0 : 32'hCAFE_F00D);

    // An ignored region leaves everything alone.
    do_op("badreg", 1'b1, 1'b0, 32'h4000_0010, 32'hFFFF_FFFF, 3'b010);

    // Back-to-back: a held request leaves busy low for exactly one cycle.
    addr = 32'h8000_0010; ctrl = 3'b010; le = 1'b1;
    exp_odata = mdl_load(32'h8000_0010, 3'b010);
    n = 0;
    @(negedge CLK);
    while (busy && n < 40) begin
      n++;
      @(negedge CLK);
    end
    check("b2b_gap_low", 32'(busy), 32'h0);
    @(negedge CLK);
    check("b2b_rearm", 32'(busy), 32'h1);
    le = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge CLK);
    end
    check("b2b_len2", 32'(n), 32'(LATENCY));
    check("b2b_odata", odata, exp_odata);
    @(negedge CLK);

    // Randomized traffic.
    for (int k = 0; k < 120; k++) begin
      logic        w;
      logic        l;
      logic [2:0]  f;
      logic [31:0] off;
      off = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) off = off + MEM_WORDS;
      a = {reg_sel[$urandom_range(0, 3)], 28'((off << 2) + 32'($urandom_range(0, 3)))};
      w = 1'($urandom_range(0, 1));
      l = w ? 1'($urandom_range(0, 1)) : 1'b1;
      f = w ? st_f[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      do_op("rnd", w, l, a, $urandom, f);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
